// File: rtl/seq_div.sv
// seq_div -- sequential restoring divider, one quotient bit per clock.
//
// An accepted start captures dividend/divisor and runs N CALC cycles, MSB
// first, then spends exactly one cycle in DONE with done high. quotient,
// remainder and div_by_zero are registered and hold until the next DONE.
// A start seen in DONE chains the next division with no idle cycle.
//
// Optional build macro:
//   SEQ_DIV_DBZ_EN  - a zero divisor skips CALC and goes directly to DONE on
//                     the next edge with div_by_zero = 1. Without it, a zero
//                     divisor runs the normal sequence and div_by_zero is 0.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        request a division (accepted in IDLE or DONE only)
//   dividend     N-bit unsigned numerator, sampled on accept
//   divisor      D-bit unsigned denominator, sampled on accept
//   busy         high while in CALC
//   done         one-cycle pulse, result valid
//   quotient     N-bit registered quotient
//   remainder    D-bit registered remainder
//   div_by_zero  registered zero-divisor flag
module seq_div #(
    parameter int N = 8,
    parameter int D = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [D-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] quotient,
    output logic [D-1:0] remainder,
    output logic         div_by_zero
);

    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state;
    state_t         state_nxt;

    logic [CW-1:0]  cnt;
    // Holds the not-yet-consumed dividend bits at the top and collects
    // quotient bits at the bottom; after N shifts it is the quotient.
    logic [N-1:0]   q_sh;
    logic [D-1:0]   prem;
    logic [D-1:0]   dsr;

    logic           accept;
    logic           last_step;
    logic           dbz_start;

    logic [D:0]     shifted;
    logic [D:0]     diff;
    logic           q_bit;
    logic [D-1:0]   prem_nxt;
    logic [N-1:0]   q_nxt;

    assign accept    = start && ((state == IDLE) || (state == DONE));
    assign last_step = (state == CALC) && (cnt == CW'(N - 1));

`ifdef SEQ_DIV_DBZ_EN
    assign dbz_start = accept && (divisor == '0);
`else
    assign dbz_start = 1'b0;
`endif

    // One restoring step. The partial remainder after a step is below the
    // divisor, so D bits suffice between steps. With a zero divisor every
    // compare succeeds and nothing is subtracted: the quotient fills with
    // ones and the remainder ends as the low D dividend bits.
    always_comb begin
        shifted  = {prem, q_sh[N-1]};
        q_bit    = (shifted >= {1'b0, dsr});
        diff     = shifted - {1'b0, dsr};
        prem_nxt = q_bit ? diff[D-1:0] : shifted[D-1:0];
        q_nxt    = (q_sh << 1) | N'(q_bit);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = dbz_start ? DONE : CALC;
                end
            end
            CALC: begin
                if (last_step) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (accept) begin
                    state_nxt = dbz_start ? DONE : CALC;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef SEQ_DIV_DBZ_EN
    logic dbz_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            q_sh      <= '0;
            prem      <= '0;
            dsr       <= '0;
            quotient  <= '0;
            remainder <= '0;
`ifdef SEQ_DIV_DBZ_EN
            dbz_q     <= 1'b0;
`endif
        end else if (accept) begin
            cnt  <= '0;
            q_sh <= dividend;
            prem <= '0;
            dsr  <= divisor;
            if (dbz_start) begin
                quotient  <= '1;
                remainder <= dividend[D-1:0];
`ifdef SEQ_DIV_DBZ_EN
                dbz_q     <= 1'b1;
`endif
            end
        end else if (state == CALC) begin
            cnt  <= cnt + 1'b1;
            q_sh <= q_nxt;
            prem <= prem_nxt;
            if (last_step) begin
                quotient  <= q_nxt;
                remainder <= prem_nxt;
`ifdef SEQ_DIV_DBZ_EN
                dbz_q     <= 1'b0;
`endif
            end
        end
    end

`ifdef SEQ_DIV_DBZ_EN
    assign div_by_zero = dbz_q;
`else
    assign div_by_zero = 1'b0;
`endif

    assign busy = (state == CALC);
    assign done = (state == DONE);

endmodule

// File: tb/tb_seq_div.sv
// Directed bench for seq_div (N=8, D=4).
module tb_seq_div;

    localparam int N = 8;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [N-1:0] dividend;
    logic [D-1:0] divisor;
    logic         busy;
    logic         done;
    logic [N-1:0] quotient;
    logic [D-1:0] remainder;
    logic         div_by_zero;

    int checks = 0;
    int errors = 0;

    seq_div #(.N(N), .D(D)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Called at a negedge. Drives start for one accepting edge, then counts
    // negedges until done is seen (latency) and busy cycles before it.
    // inj != 0 pulses start with 100/3 at that CALC cycle.
    task automatic run_op(input logic [N-1:0] a, input logic [D-1:0] b, input int inj,
                          output int lat, output int bsy);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = '0;
        divisor  = 4'hF;
        lat = 0;
        bsy = 0;
        for (int k = 1; k <= 20 && lat == 0; k++) begin
            @(negedge clk);
            if (done) lat = k;
            else if (busy) bsy++;
            if (inj != 0 && k == inj) begin
                start    = 1'b1;
                dividend = 8'd100;
                divisor  = 4'd3;
            end
            if (inj != 0 && k == inj + 1) begin
                start    = 1'b0;
                dividend = '0;
                divisor  = 4'hF;
            end
        end
    endtask

    initial begin
        int lat;
        int bsy;
        int ndone;

        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_quot", 32'(quotient), 32'd0);
        chk("rst_rem",  32'(remainder), 32'd0);
        chk("rst_dbz",  32'(div_by_zero), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // 225 / 15
        run_op(8'd225, 4'd15, 0, lat, bsy);
        chk("t1_lat",  32'(lat), 32'd9);
        chk("t1_busy", 32'(bsy), 32'd8);
        chk("t1_quot", 32'(quotient), 32'd15);
        chk("t1_rem",  32'(remainder), 32'd0);
        chk("t1_dbz",  32'(div_by_zero), 32'd0);
        @(negedge clk);
        chk("t1_done_pulse", 32'(done), 32'd0);
        chk("t1_idle_busy",  32'(busy), 32'd0);
        chk("t1_hold_quot",  32'(quotient), 32'd15);

        // 200 / 7 then back-to-back 54 / 6 with start high in DONE
        run_op(8'd200, 4'd7, 0, lat, bsy);
        chk("t2a_lat",  32'(lat), 32'd9);
        chk("t2a_quot", 32'(quotient), 32'd28);
        chk("t2a_rem",  32'(remainder), 32'd4);
        run_op(8'd54, 4'd6, 0, lat, bsy);
        chk("t2b_lat",  32'(lat), 32'd9);
        chk("t2b_busy", 32'(bsy), 32'd8);
        chk("t2b_quot", 32'(quotient), 32'd9);
        chk("t2b_rem",  32'(remainder), 32'd0);
        @(negedge clk);

        // dividend below divisor, and divide by one
        run_op(8'd5, 4'd9, 0, lat, bsy);
        chk("t3a_lat",  32'(lat), 32'd9);
        chk("t3a_quot", 32'(quotient), 32'd0);
        chk("t3a_rem",  32'(remainder), 32'd5);
        @(negedge clk);
        run_op(8'd255, 4'd1, 0, lat, bsy);
        chk("t3b_lat",  32'(lat), 32'd9);
        chk("t3b_quot", 32'(quotient), 32'd255);
        chk("t3b_rem",  32'(remainder), 32'd0);
        @(negedge clk);

        // start pulsed with 100/3 during CALC cycle 3 of 200/7
        run_op(8'd200, 4'd7, 3, lat, bsy);
        chk("t4_lat",  32'(lat), 32'd9);
        chk("t4_quot", 32'(quotient), 32'd28);
        chk("t4_rem",  32'(remainder), 32'd4);
        ndone = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("t4_extra_done", 32'(ndone), 32'd0);
        chk("t4_idle_busy",  32'(busy), 32'd0);

        // reset at CALC cycle 4 of 255/15
        start    = 1'b1;
        dividend = 8'd255;
        divisor  = 4'd15;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("t5_busy_pre", 32'(busy), 32'd1);
        chk("t5_hold_quot", 32'(quotient), 32'd28);
        rst_n = 1'b0;
        #1;
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_done", 32'(done), 32'd0);
        chk("t5_quot", 32'(quotient), 32'd0);
        chk("t5_rem",  32'(remainder), 32'd0);
        chk("t5_dbz",  32'(div_by_zero), 32'd0);
        ndone = 0;
        repeat (2) begin
            @(negedge clk);
            if (done) ndone++;
        end
        rst_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (done || busy) ndone++;
        end
        chk("t5_no_done", 32'(ndone), 32'd0);
        run_op(8'd9, 4'd3, 0, lat, bsy);
        chk("t5_lat",  32'(lat), 32'd9);
        chk("t5_q93",  32'(quotient), 32'd3);
        chk("t5_r93",  32'(remainder), 32'd0);
        @(negedge clk);

        // divide by zero: 0xA5 / 0
        run_op(8'hA5, 4'd0, 0, lat, bsy);
        chk("t6_quot", 32'(quotient), 32'hFF);
        chk("t6_rem",  32'(remainder), 32'd5);
`ifdef SEQ_DIV_DBZ_EN
        chk("t6_lat",  32'(lat), 32'd1);
        chk("t6_busy", 32'(bsy), 32'd0);
        chk("t6_dbz",  32'(div_by_zero), 32'd1);
`else
        chk("t6_lat",  32'(lat), 32'd9);
        chk("t6_busy", 32'(bsy), 32'd8);
        chk("t6_dbz",  32'(div_by_zero), 32'd0);
`endif
        @(negedge clk);
        chk("t6_done_pulse", 32'(done), 32'd0);
        chk("t6_hold_quot",  32'(quotient), 32'hFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
